pe_array_data_out_collector: RTL
================================

PE_ARRAY_DATA_OUT_COLLECTOR -- requirements
Module: pe_array_data_out_collector

Interface
REQ-001 The block SHALL be parameterized as follows (name, default, meaning):
- num_pe_col, 16, PE array columns.
- psum_width, 32, PE output (accumulated psum) width.
- activation_width, 16, quantized output width.
- addr_width, 12, output-buffer word address width.
- row_cnt_width, 8, per-column row counter width.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, the only clock.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, begin a collection job; sampled in IDLE only.
- base_addr, in, addr_width, job base address; latched on start.
- num_rows, in, row_cnt_width, rows per column; latched on start.
- shift, in, 5, arithmetic right shift; latched on start.
- relu_en, in, 1, clamp negatives to 0; latched on start.
- pe_out_valid, in, num_pe_col, per-column PE result valid.
- pe_out_data, in, num_pe_col x psum_width, per-column signed psum.
- pe_out_ready, out, num_pe_col, per-column accept.
- obuf_wr_en, out, 1, output-buffer write strobe.
- obuf_wr_addr, out, addr_width, write address.
- obuf_wr_data, out, activation_width, quantized write data.
- obuf_wr_ready, in, 1, buffer accepts the write this cycle.
- busy, out, 1, high in COLLECT.
- done, out, 1, one-cycle completion pulse.
REQ-003 The clock SHALL be clk; reset SHALL be rst_n, asynchronous, active-low.

Function
REQ-004 FSM states SHALL be IDLE, COLLECT and DONE; transitions: IDLE->COLLECT on start; COLLECT->DONE when all columns have written num_rows results and no holding register is valid; DONE->IDLE unconditionally after one cycle.
REQ-005 start in COLLECT or DONE SHALL be ignored; start with num_rows=0 SHALL go IDLE->COLLECT->DONE with zero writes.
REQ-006 Each column SHALL own a one-entry holding register (hold_vld, hold_data) and a capture counter cap_cnt and a write counter wr_cnt.
REQ-007 pe_out_ready[c] SHALL be: state==COLLECT && cap_cnt[c]<num_rows && (!hold_vld[c] || (grant[c] && obuf_wr_ready)).
REQ-008 A capture SHALL occur when pe_out_valid[c] && pe_out_ready[c]; it loads hold_data[c] and increments cap_cnt[c]. pe_out_data SHALL be held stable by the PE side while valid && !ready.
REQ-009 A round-robin arbiter SHALL grant one valid holding register per cycle. The search starts at the column after the last granted one and wraps from num_pe_col-1 to 0; the pointer advances only on a completed write.
REQ-010 Write output signals:
- obuf_wr_en = state==COLLECT && |hold_vld.
- obuf_wr_addr = base_addr + wr_cnt[g]*num_pe_col + g, where g is the granted column, modulo 2^addr_width.
- obuf_wr_data = quantized hold_data[g].
REQ-011 A write SHALL complete when obuf_wr_en && obuf_wr_ready; it clears hold_vld[g] and increments wr_cnt[g]. A simultaneous recapture into the same column in that cycle SHALL set hold_vld[g] again with the new data.
REQ-012 Quantization SHALL be combinational on hold_data: arithmetic right shift by shift, truncation toward -inf; if relu_en and the result is negative, use 0; then saturate to signed activation_width (max 0x7FFF, min 0x8000).
REQ-013 Latency: a capture at edge t SHALL allow obuf_wr_en at cycle t+1 at the earliest. Sustained throughput SHALL be one write per cycle while obuf_wr_ready is high.
REQ-014 While obuf_wr_ready is low, obuf_wr_addr, obuf_wr_data and grant SHALL stay stable.
REQ-015 done SHALL be high only in DONE; busy SHALL be high only in COLLECT.

Reset
REQ-016 rst_n low SHALL, at any time including mid-job, force IDLE and clear all hold_vld, cap_cnt, wr_cnt, the arbiter pointer and the latched job parameters. Outputs SHALL read 0: pe_out_ready, obuf_wr_en, obuf_wr_addr, obuf_wr_data, busy, done.
REQ-017 After reset is released, the first start SHALL behave as a fresh job; no partial writes from the aborted job SHALL appear.

Structure
REQ-018 A shared package pe_array_out_pkg SHALL hold the FSM state enum and the default width constants.
REQ-019 The round-robin arbiter SHALL be a separate sub-module rr_arbiter, parameterized by requester count. Quantization SHALL stay inline.

Verification
REQ-020 Reset state: assert rst_n=0 mid-job, then release -> all outputs 0, state IDLE; a new start succeeds.
REQ-021 Full-rate job: num_rows=2, base_addr=0x100, shift=0, all 16 columns valid every cycle, obuf_wr_ready=1 -> 32 writes in consecutive cycles to addresses 0x100..0x11F in column order, then a done pulse.
REQ-022 Backpressure: obuf_wr_ready held 0 for 5 cycles with columns 3 and 7 holding data -> addr/data stable and pe_out_ready[3]=pe_out_ready[7]=0; on release, col 3 writes, then col 7 writes.
REQ-023 Quantization: psum 0x0001_2345 with shift=4 -> 0x1234; 0x7FFF_FFFF with shift=0 -> 0x7FFF; -5 with relu_en=1 -> 0x0000; -5 with relu_en=0 -> 0xFFFB.
REQ-024 Wrap and edge cases: base_addr=0xFFF0 with num_rows=1 -> addresses 0xFFF0..0xFFFF (16-bit addr config); num_rows=0 -> done 2 cycles after start, no writes; start during COLLECT -> ignored.
REQ-025 Same-cycle write plus recapture: single column 5 valid every cycle, num_rows=4 -> 4 writes on back-to-back cycles, row addresses base+5, +21, +37, +53.

Source files
------------

// File: rtl/pe_array_out_pkg.sv
// Shared types and default sizing for the PE-array output collector.
// Holds the job FSM encoding used by the collector and its bench.
package pe_array_out_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DONE    = 2'd2
   } state_e;

   localparam int unsigned default_num_pe_col       = 16;
   localparam int unsigned default_psum_width       = 32;
   localparam int unsigned default_activation_width = 16;
   localparam int unsigned default_addr_width       = 12;
   localparam int unsigned default_row_cnt_width    = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one grant per cycle, search starts after the last served requester.
// A grant that is not consumed is held until it is, so the winner cannot change under a stall.
module rr_arbiter #(
   parameter int unsigned num_req = 16,
   parameter int unsigned idx_w   = (num_req > 1) ? $clog2(num_req) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               restart,
   input  logic [num_req-1:0] req,
   input  logic               advance,
   output logic [num_req-1:0] grant,
   output logic [idx_w-1:0]   grant_idx,
   output logic               grant_vld
);

   logic [idx_w-1:0] ptr_q;
   logic [idx_w-1:0] lock_idx_q;
   logic             lock_q;
   logic [idx_w-1:0] search_idx;
   logic             search_vld;
   logic [idx_w-1:0] cand;

   always_comb begin
      search_idx = '0;
      search_vld = 1'b0;
      cand       = '0;
      for (int unsigned i = 0; i < num_req; i++) begin
         cand = idx_w'((32'(ptr_q) + i) % num_req);
         if (!search_vld && req[cand]) begin
            search_vld = 1'b1;
            search_idx = cand;
         end
      end
      if (lock_q) begin
         grant_idx = lock_idx_q;
         grant_vld = req[lock_idx_q];
      end else begin
         grant_idx = search_idx;
         grant_vld = search_vld;
      end
      grant = '0;
      if (grant_vld) grant[grant_idx] = 1'b1;
   end

   // ptr_q is the first requester examined, so a cleared pointer favours column 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q      <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
      end else if (restart) begin
         ptr_q      <= '0;
         lock_q     <= 1'b0;
      end else begin
         lock_q     <= grant_vld && !advance;
         lock_idx_q <= grant_idx;
         if (grant_vld && advance)
            ptr_q <= (32'(grant_idx) == num_req - 1) ? '0 : grant_idx + 1'b1;
      end
   end

endmodule

// File: rtl/pe_array_data_out_collector.sv
// Collects per-column PE psums into one-entry holding registers, quantizes them and
// streams them round-robin into the output buffer at base + row*num_pe_col + col.
module pe_array_data_out_collector
   import pe_array_out_pkg::*;
#(
   parameter int unsigned num_pe_col       = default_num_pe_col,
   parameter int unsigned psum_width       = default_psum_width,
   parameter int unsigned activation_width = default_activation_width,
   parameter int unsigned addr_width       = default_addr_width,
   parameter int unsigned row_cnt_width    = default_row_cnt_width
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   input  logic [addr_width-1:0]            base_addr,
   input  logic [row_cnt_width-1:0]         num_rows,
   input  logic [4:0]                       shift,
   input  logic                             relu_en,
   input  logic [num_pe_col-1:0]            pe_out_valid,
   input  logic [num_pe_col*psum_width-1:0] pe_out_data,
   output logic [num_pe_col-1:0]            pe_out_ready,
   output logic                             obuf_wr_en,
   output logic [addr_width-1:0]            obuf_wr_addr,
   output logic [activation_width-1:0]      obuf_wr_data,
   input  logic                             obuf_wr_ready,
   output logic                             busy,
   output logic                             done
);

   localparam int unsigned col_idx_w = (num_pe_col > 1) ? $clog2(num_pe_col) : 1;

   state_e                         state_q;
   logic [addr_width-1:0]          base_q;
   logic [row_cnt_width-1:0]       rows_q;
   logic [4:0]                     shift_q;
   logic                           relu_q;
   logic [num_pe_col-1:0]          hold_vld_q;
   logic signed [psum_width-1:0]   hold_data_q [num_pe_col];
   logic [row_cnt_width-1:0]       cap_cnt_q   [num_pe_col];
   logic [row_cnt_width-1:0]       wr_cnt_q    [num_pe_col];

   logic                           collect;
   logic                           restart;
   logic                           wr_fire;
   logic                           all_written;
   logic [num_pe_col-1:0]          cap;
   logic [num_pe_col-1:0]          grant;
   logic [col_idx_w-1:0]           grant_idx;
   logic                           grant_vld;

   function automatic logic signed [activation_width-1:0] saturate(
      input logic signed [psum_width-1:0] v);
      logic signed [psum_width-1:0] hi;
      logic signed [psum_width-1:0] lo;
      hi = {{(psum_width-activation_width+1){1'b0}}, {(activation_width-1){1'b1}}};
      lo = ~hi;
      if (v > hi)      return {1'b0, {(activation_width-1){1'b1}}};
      else if (v < lo) return {1'b1, {(activation_width-1){1'b0}}};
      else             return v[activation_width-1:0];
   endfunction

   // Arithmetic shift floors toward -inf; ReLU is applied before saturation
   function automatic logic signed [activation_width-1:0] quantize(
      input logic signed [psum_width-1:0] v,
      input logic [4:0]                   sh,
      input logic                         relu);
      logic signed [psum_width-1:0] s;
      s = v >>> sh;
      if (relu && s < 0) s = '0;
      return saturate(s);
   endfunction

   assign collect    = (state_q == ST_COLLECT);
   assign restart    = (state_q == ST_IDLE) && start;
   assign obuf_wr_en = collect && |hold_vld_q;
   assign wr_fire    = obuf_wr_en && obuf_wr_ready;
   assign busy       = collect;
   assign done       = (state_q == ST_DONE);

   rr_arbiter #(
      .num_req (num_pe_col),
      .idx_w   (col_idx_w)
   ) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .restart   (restart),
      .req       (hold_vld_q),
      .advance   (wr_fire),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_vld (grant_vld)
   );

   // A full holding register may still accept when its content leaves this same cycle
   always_comb begin
      pe_out_ready = '0;
      for (int c = 0; c < num_pe_col; c++)
         pe_out_ready[c] = collect && (cap_cnt_q[c] < rows_q) &&
                           (!hold_vld_q[c] || (grant[c] && obuf_wr_ready));
      cap = pe_out_valid & pe_out_ready;
   end

   always_comb begin
      all_written = ~|hold_vld_q;
      for (int c = 0; c < num_pe_col; c++)
         if (wr_cnt_q[c] != rows_q) all_written = 1'b0;
   end

   always_comb begin
      obuf_wr_addr = '0;
      obuf_wr_data = '0;
      if (obuf_wr_en && grant_vld) begin
         obuf_wr_addr = base_q + addr_width'(wr_cnt_q[grant_idx]) * addr_width'(num_pe_col)
                        + addr_width'(grant_idx);
         obuf_wr_data = quantize(hold_data_q[grant_idx], shift_q, relu_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         base_q     <= '0;
         rows_q     <= '0;
         shift_q    <= '0;
         relu_q     <= 1'b0;
         hold_vld_q <= '0;
         for (int c = 0; c < num_pe_col; c++) begin
            cap_cnt_q[c] <= '0;
            wr_cnt_q[c]  <= '0;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q <= ST_COLLECT;
                  base_q  <= base_addr;
                  rows_q  <= num_rows;
                  shift_q <= shift;
                  relu_q  <= relu_en;
                  for (int c = 0; c < num_pe_col; c++) begin
                     cap_cnt_q[c] <= '0;
                     wr_cnt_q[c]  <= '0;
                  end
               end
            end
            ST_COLLECT: if (all_written) state_q <= ST_DONE;
            default:    state_q <= ST_IDLE;
         endcase
         for (int c = 0; c < num_pe_col; c++) begin
            if (wr_fire && grant[c]) begin
               hold_vld_q[c] <= 1'b0;
               wr_cnt_q[c]   <= wr_cnt_q[c] + 1'b1;
            end
            if (cap[c]) begin
               hold_vld_q[c] <= 1'b1;
               cap_cnt_q[c]  <= cap_cnt_q[c] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int c = 0; c < num_pe_col; c++)
         if (cap[c]) hold_data_q[c] <= pe_out_data[c*psum_width +: psum_width];
   end

endmodule
